// File: rtl/sram_tile_streamer.sv
// Tile read sequencer: walks K then row on a 1-cycle SRAM port into a credit FIFO.
// Optional TILE_STREAMER_ZERO_PAD_EN pads every row out to KMAX zero elements.
module sram_tile_streamer #(
   parameter int M          = 8,
   parameter int KMAX       = 8,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4,
   localparam int ROW_W = (M <= 1) ? 1 : $clog2(M),
   localparam int K_W   = (KMAX <= 1) ? 1 : $clog2(KMAX)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ROW_W-1:0]      cmd_row_base,
   input  logic [ROW_W:0]        cmd_rows,
   input  logic [K_W:0]          cmd_k_len,
   output logic                  m_en,
   output logic                  m_re,
   output logic                  m_we,
   output logic [ROW_W-1:0]      m_row,
   output logic [K_W-1:0]        m_k,
   output logic [DATA_W-1:0]     m_wdata,
   output logic [DATA_W/8-1:0]   m_wmask,
   input  logic [DATA_W-1:0]     m_rdata,
   input  logic                  m_rvalid,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_data,
   output logic [ROW_W-1:0]      out_row,
   output logic [K_W-1:0]        out_k,
   output logic                  out_last_k,
   output logic                  out_last,
   output logic                  done
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

   state_t              r_state, w_next;
   logic [ROW_W-1:0]    r_base;
   logic [ROW_W:0]      r_rows, r_rcnt;
   logic [K_W:0]        r_klen, r_kcnt;
   logic                r_inflight;
   logic [ROW_W-1:0]    r_tag_row;
   logic [K_W-1:0]      r_tag_k;
   logic                r_tag_lk, r_tag_l;

   logic [DATA_W-1:0]   r_fd  [FIFO_DEPTH];
   logic [ROW_W-1:0]    r_fr  [FIFO_DEPTH];
   logic [K_W-1:0]      r_fk  [FIFO_DEPTH];
   logic                r_flk [FIFO_DEPTH];
   logic                r_fl  [FIFO_DEPTH];
   logic [PW-1:0]       r_wp, r_rp;
   logic [CW-1:0]       r_count;

   logic [ROW_W:0]      w_row_sum;
   logic [ROW_W-1:0]    w_row;
   logic                w_credit, w_pad_col, w_k_last, w_r_last;
   logic                w_issue, w_pad, w_step;
   logic                w_push_rd, w_push, w_pop, w_empty;

   assign w_row_sum = {1'b0, r_base} + r_rcnt;
   assign w_row     = (w_row_sum >= (ROW_W+1)'(M)) ?
                      ROW_W'(w_row_sum - (ROW_W+1)'(M)) :
                      w_row_sum[ROW_W-1:0];
   assign w_credit  = ({1'b0, r_count} + (CW+1)'(r_inflight))
                      < (CW+1)'(FIFO_DEPTH);
   assign w_r_last  = (r_rcnt == r_rows - (ROW_W+1)'(1));

`ifdef TILE_STREAMER_ZERO_PAD_EN
   // Pad columns wait for the in-flight read so FIFO order matches k order
   assign w_pad_col = (r_kcnt >= r_klen);
   assign w_k_last  = (r_kcnt == (K_W+1)'(KMAX - 1));
   assign w_pad     = (r_state == S_ISSUE) && w_pad_col && w_credit
                      && !r_inflight && !rst;
`else
   assign w_pad_col = 1'b0;
   assign w_k_last  = (r_kcnt == r_klen - (K_W+1)'(1));
   assign w_pad     = 1'b0;
`endif

   assign w_issue   = (r_state == S_ISSUE) && !w_pad_col && w_credit && !rst;
   assign w_step    = w_issue | w_pad;
   assign w_push_rd = m_rvalid && r_inflight;
   assign w_push    = w_push_rd | w_pad;
   assign w_empty   = (r_count == '0);
   assign w_pop     = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      cmd_ready = 1'b0;
      done      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            cmd_ready = !rst;
            if (cmd_valid && !rst)
               w_next = (cmd_rows == '0 || cmd_k_len == '0) ? S_DRAIN : S_ISSUE;
         end
         S_ISSUE: begin
            if (w_step && w_k_last && w_r_last) w_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (!r_inflight && w_empty) begin
               done   = !rst;
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_base     <= '0;
         r_rows     <= '0;
         r_klen     <= '0;
         r_rcnt     <= '0;
         r_kcnt     <= '0;
         r_inflight <= 1'b0;
         r_tag_row  <= '0;
         r_tag_k    <= '0;
         r_tag_lk   <= 1'b0;
         r_tag_l    <= 1'b0;
      end else begin
         if (cmd_valid && cmd_ready) begin
            r_base <= cmd_row_base;
            r_rows <= cmd_rows;
            r_klen <= cmd_k_len;
            r_rcnt <= '0;
            r_kcnt <= '0;
         end else if (w_step) begin
            if (w_k_last) begin
               r_kcnt <= '0;
               r_rcnt <= r_rcnt + (ROW_W+1)'(1);
            end else begin
               r_kcnt <= r_kcnt + (K_W+1)'(1);
            end
         end
         if (w_issue)        r_inflight <= 1'b1;
         else if (w_push_rd) r_inflight <= 1'b0;
         if (w_issue) begin
            r_tag_row <= w_row;
            r_tag_k   <= r_kcnt[K_W-1:0];
            r_tag_lk  <= w_k_last;
            r_tag_l   <= w_k_last && w_r_last;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fd[r_wp]  <= w_pad ? '0 : m_rdata;
         r_fr[r_wp]  <= w_pad ? w_row : r_tag_row;
         r_fk[r_wp]  <= w_pad ? r_kcnt[K_W-1:0] : r_tag_k;
         r_flk[r_wp] <= w_pad ? w_k_last : r_tag_lk;
         r_fl[r_wp]  <= w_pad ? (w_k_last && w_r_last) : r_tag_l;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
      end else begin
         if (w_push)
            r_wp <= (r_wp == PW'(FIFO_DEPTH - 1)) ? '0 : r_wp + PW'(1);
         if (w_pop)
            r_rp <= (r_rp == PW'(FIFO_DEPTH - 1)) ? '0 : r_rp + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign m_en    = w_issue;
   assign m_re    = w_issue;
   assign m_we    = 1'b0;
   assign m_row   = w_issue ? w_row : '0;
   assign m_k     = w_issue ? r_kcnt[K_W-1:0] : '0;
   assign m_wdata = '0;
   assign m_wmask = '0;

   assign out_valid  = !w_empty && !rst;
   assign out_data   = out_valid ? r_fd[r_rp]  : '0;
   assign out_row    = out_valid ? r_fr[r_rp]  : '0;
   assign out_k      = out_valid ? r_fk[r_rp]  : '0;
   assign out_last_k = out_valid ? r_flk[r_rp] : 1'b0;
   assign out_last   = out_valid ? r_fl[r_rp]  : 1'b0;

endmodule

// File: tb/tb_sram_tile_streamer.sv
// Scoreboard bench for sram_tile_streamer with a 1-cycle SRAM model.
// Build with TILE_STREAMER_ZERO_PAD_EN to exercise the KMAX=8 pad path.
module tb_sram_tile_streamer;

   localparam int M = 4;
`ifdef TILE_STREAMER_ZERO_PAD_EN
   localparam int KMAX = 8;
   localparam bit PAD  = 1'b1;
`else
   localparam int KMAX = 4;
   localparam bit PAD  = 1'b0;
`endif
   localparam int DW    = 32;
   localparam int FD    = 4;
   localparam int ROW_W = (M <= 1) ? 1 : $clog2(M);
   localparam int K_W   = (KMAX <= 1) ? 1 : $clog2(KMAX);

   typedef struct packed {
      logic [DW-1:0]    d;
      logic [ROW_W-1:0] r;
      logic [K_W-1:0]   k;
      logic             lk;
      logic             l;
   } elem_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [ROW_W-1:0] cmd_row_base;
   logic [ROW_W:0]   cmd_rows;
   logic [K_W:0]     cmd_k_len;
   logic             m_en, m_re, m_we;
   logic [ROW_W-1:0] m_row;
   logic [K_W-1:0]   m_k;
   logic [DW-1:0]    m_wdata;
   logic [DW/8-1:0]  m_wmask;
   logic [DW-1:0]    m_rdata = '0;
   logic             m_rvalid = 1'b0;
   logic             out_valid, out_ready;
   logic [DW-1:0]    out_data;
   logic [ROW_W-1:0] out_row;
   logic [K_W-1:0]   out_k;
   logic             out_last_k, out_last, done;

   sram_tile_streamer #(
      .M(M), .KMAX(KMAX), .DATA_W(DW), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_row_base(cmd_row_base), .cmd_rows(cmd_rows),
      .cmd_k_len(cmd_k_len),
      .m_en(m_en), .m_re(m_re), .m_we(m_we),
      .m_row(m_row), .m_k(m_k),
      .m_wdata(m_wdata), .m_wmask(m_wmask),
      .m_rdata(m_rdata), .m_rvalid(m_rvalid),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_row(out_row), .out_k(out_k),
      .out_last_k(out_last_k), .out_last(out_last),
      .done(done)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] memval(input int r, input int k);
      logic [15:0] x;
      x = 16'hA55A ^ 16'(r * 17 + k);
      return {8'(r), 8'(k), x};
   endfunction

   // SRAM: one-cycle read latency
   always @(posedge clk) begin
      m_rvalid <= m_en & m_re;
      if (m_en & m_re) m_rdata <= memval(int'(m_row), int'(m_k));
   end

   elem_t sb[$];
   int cyc = 0;
   int t_acc = 0, t_first = -1, t_done = -1;
   int n_done = 0, n_strobe = 0, n_pop = 0, n_viol = 0, occ = 0;
   bit bp = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      elem_t e;
      if (cmd_valid && cmd_ready) begin
         t_acc = cyc; t_first = -1; t_done = -1; n_done = 0;
         n_strobe = 0; n_pop = 0; n_viol = 0; occ = 0;
      end
      if (m_en) begin
         if (occ >= FD) n_viol++;
         n_strobe++;
         occ++;
      end
      if (out_valid && t_first < 0) t_first = cyc;
      if (out_valid && out_ready) begin
         occ--;
         n_pop++;
         check("sb_has_entry", 64'(sb.size() > 0), 64'(1));
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("out_data", 64'(out_data), 64'(e.d));
            check("out_row", 64'(out_row), 64'(e.r));
            check("out_k", 64'(out_k), 64'(e.k));
            check("out_last_k", 64'(out_last_k), 64'(e.lk));
            check("out_last", 64'(out_last), 64'(e.l));
         end
      end
      if (done) begin
         n_done++;
         t_done = cyc;
      end
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      end
   end

   task automatic start_tile(input int base, input int rows,
                             input int klen, output int n);
      int nk, tmo;
      elem_t e;
      nk = PAD ? KMAX : klen;
      n  = (rows == 0 || klen == 0) ? 0 : rows * nk;
      if (n > 0)
         for (int r = 0; r < rows; r++)
            for (int k = 0; k < nk; k++) begin
               e.d  = (k < klen) ? memval((base + r) % M, k) : '0;
               e.r  = ROW_W'((base + r) % M);
               e.k  = K_W'(k);
               e.lk = (k == nk - 1);
               e.l  = (k == nk - 1) && (r == rows - 1);
               sb.push_back(e);
            end
      @(posedge clk);
      #1;
      cmd_valid    = 1'b1;
      cmd_row_base = ROW_W'(base);
      cmd_rows     = (ROW_W+1)'(rows);
      cmd_k_len    = (K_W+1)'(klen);
      tmo = 0;
      do begin
         @(negedge clk);
         tmo++;
      end while (!cmd_ready && tmo < 100);
      if (!cmd_ready) check("cmd_accept_timeout", 64'(cmd_ready), 64'(1));
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic finish_tile(input string nm, input int rows,
                              input int klen, input int n);
      int tmo;
      bit timed;
      timed = !bp && (!PAD || klen == KMAX || n == 0);
      tmo = 0;
      while (n_done == 0 && tmo < 2000) begin
         @(posedge clk);
         tmo++;
      end
      check({nm, "_done_seen"}, 64'(n_done), 64'(1));
      @(negedge clk);
      check({nm, "_done_pulse"}, 64'(n_done), 64'(1));
      check({nm, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
      check({nm, "_sb_empty"}, 64'(sb.size()), 64'(0));
      check({nm, "_pops"}, 64'(n_pop), 64'(n));
      check({nm, "_strobes"}, 64'(n_strobe),
            64'((n == 0) ? 0 : rows * klen));
      check({nm, "_credit"}, 64'(n_viol), 64'(0));
      if (timed) begin
         check({nm, "_t_done"}, 64'(t_done),
               64'(t_acc + ((n == 0) ? 1 : 3 + n)));
         check({nm, "_t_first"}, 64'(t_first),
               64'((n == 0) ? -1 : t_acc + 3));
      end
   endtask

   task automatic run_tile(input string nm, input int base,
                           input int rows, input int klen);
      int n;
      start_tile(base, rows, klen, n);
      finish_tile(nm, rows, klen, n);
   endtask

   initial begin
      int n, tmo;
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_row_base = '0;
      cmd_rows = '0;
      cmd_k_len = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
      check("rst_m_en", 64'(m_en), 64'(0));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("idle_cmd_ready", 64'(cmd_ready), 64'(1));
      check("idle_out_data", 64'(out_data), 64'(0));
      check("idle_m_we", 64'(m_we), 64'(0));

      run_tile("basic", 0, 4, KMAX);
      run_tile("wrap", 3, 2, 2);
      bp = 1'b1;
      run_tile("bp", 0, 4, KMAX);
      bp = 1'b0;
      run_tile("empty_rows", 1, 0, 3);
      run_tile("empty_k", 2, 3, 0);

      start_tile(0, 4, KMAX, n);
      tmo = 0;
      while (n_pop < 5 && tmo < 200) begin
         @(posedge clk);
         tmo++;
      end
      check("rst_mid_pops", 64'(n_pop >= 5), 64'(1));
      #1;
      rst = 1'b1;
      n_done = 0;
      @(negedge clk);
      check("rst_mid_cmd_ready", 64'(cmd_ready), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
      check("rst_mid_out_valid", 64'(out_valid), 64'(0));
      check("rst_mid_m_en", 64'(m_en), 64'(0));
      check("rst_mid_out_data", 64'(out_data), 64'(0));
      check("rst_mid_out_last", 64'(out_last), 64'(0));
      check("rst_mid_cmd_ready1", 64'(cmd_ready), 64'(1));
      repeat (10) @(negedge clk);
      check("rst_mid_no_done", 64'(n_done), 64'(0));

      run_tile("after_rst", 0, 4, KMAX);
      run_tile("short_row", 1, 1, 3);
      run_tile("full_wrap", 2, 4, KMAX);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
